// File: rtl/game_board_checker.sv
// game_board_checker: NxN two-player board with move handshake,
// one-line-per-cycle win/draw scan and optional turn timeout.
module game_board_checker #(
  parameter int N = 3,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int CW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_new_game,
  input  logic          i_move_valid,
  output logic          o_move_ready,
  input  logic [CW-1:0] i_move_row,
  input  logic [CW-1:0] i_move_col,
  output logic          o_move_accept,
  output logic          o_move_reject,
  output logic          o_timeout,
  output logic          o_current_player,
  output logic          o_game_over,
  output logic [1:0]    o_winner,
  output logic          o_draw,
  input  logic [CW-1:0] i_rd_row,
  input  logic [CW-1:0] i_rd_col,
  output logic [1:0]    o_rd_data
);
  localparam int NC = N * N;
  localparam int IW = $clog2(NC);
  localparam int FW = $clog2(NC + 1);
  localparam int LW = $clog2(2 * N + 2);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LW-1:0] L_LAST = LW'(2 * N + 1);
  localparam logic [FW-1:0] F_FULL = FW'(NC);
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_OVER} state_t;

  state_t        r_state;
  logic [1:0]    r_cells [NC];
  logic [FW-1:0] r_fill;
  logic [LW-1:0] r_line;
  logic [TW-1:0] r_tcnt;
  logic          r_player;
  logic          r_accept;
  logic          r_reject;
  logic          r_timeout;
  logic          r_draw;
  logic [1:0]    r_winner;

  logic          w_hs;
  logic          w_mv_in;
  logic          w_rd_in;
  logic          w_legal;
  logic          w_expire;
  logic          w_line_win;
  logic [IW-1:0] w_mv_idx;
  logic [IW-1:0] w_rd_idx;
  logic [1:0]    w_code;
  logic [1:0]    w_mv_cell;

  assign w_code   = r_player ? 2'b10 : 2'b01;
  assign w_hs     = i_move_valid && (r_state == S_IDLE);
  assign w_mv_in  = (int'(i_move_row) < N) && (int'(i_move_col) < N);
  assign w_rd_in  = (int'(i_rd_row) < N) && (int'(i_rd_col) < N);
  assign w_mv_idx = IW'(int'(i_move_row) * N + int'(i_move_col));
  assign w_rd_idx = IW'(int'(i_rd_row) * N + int'(i_rd_col));
  assign w_mv_cell = w_mv_in ? r_cells[w_mv_idx] : 2'b11;
  assign w_legal  = (w_mv_cell == 2'b00);
  assign w_expire = (TIMEOUT_CYCLES > 0) && (r_state == S_IDLE) &&
                    !w_hs && (r_tcnt == T_LAST);

  assign o_move_ready     = (r_state == S_IDLE);
  assign o_game_over      = (r_state == S_OVER);
  assign o_move_accept    = r_accept;
  assign o_move_reject    = r_reject;
  assign o_timeout        = r_timeout;
  assign o_current_player = r_player;
  assign o_winner         = r_winner;
  assign o_draw           = r_draw;
  assign o_rd_data        = w_rd_in ? r_cells[w_rd_idx] : 2'b00;

  // Line r_line wins when every one of its N cells holds the mover's code
  always_comb begin
    int r;
    int c;
    int l;
    r = 0;
    c = 0;
    l = int'(r_line);
    w_line_win = 1'b1;
    for (int k = 0; k < N; k++) begin
      r = k;
      c = k;
      if (l < N) begin
        r = l;
      end else if (l < 2 * N) begin
        c = l - N;
      end else if (l == 2 * N + 1) begin
        c = N - 1 - k;
      end
      if (r_cells[IW'(r * N + c)] != w_code) w_line_win = 1'b0;
    end
  end

  // Board state machine: handshake, line scan, game over, turn timer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NC; i++) r_cells[IW'(i)] <= 2'b00;
      r_state   <= S_IDLE;
      r_fill    <= '0;
      r_line    <= '0;
      r_tcnt    <= '0;
      r_player  <= 1'b0;
      r_accept  <= 1'b0;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      r_draw    <= 1'b0;
      r_winner  <= 2'b00;
    end else begin
      r_accept  <= 1'b0;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      if (i_new_game) begin
        for (int i = 0; i < NC; i++) r_cells[IW'(i)] <= 2'b00;
        r_state  <= S_IDLE;
        r_fill   <= '0;
        r_line   <= '0;
        r_tcnt   <= '0;
        r_player <= 1'b0;
        r_draw   <= 1'b0;
        r_winner <= 2'b00;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_hs && w_legal) begin
              r_cells[w_mv_idx] <= w_code;
              r_fill   <= r_fill + 1'b1;
              r_accept <= 1'b1;
              r_line   <= '0;
              r_tcnt   <= '0;
              r_state  <= S_CHECK;
            end else if (w_expire) begin
              r_timeout <= 1'b1;
              r_player  <= ~r_player;
              r_tcnt    <= '0;
            end else begin
              r_reject <= w_hs;
              // Saturate so a reject in the expiry cycle defers the timeout
              if (TIMEOUT_CYCLES > 0 && r_tcnt != T_LAST)
                r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_CHECK: begin
            if (w_line_win) begin
              r_winner <= w_code;
              r_state  <= S_OVER;
            end else if (r_line == L_LAST) begin
              if (r_fill == F_FULL) begin
                r_draw  <= 1'b1;
                r_state <= S_OVER;
              end else begin
                r_player <= ~r_player;
                r_tcnt   <= '0;
                r_state  <= S_IDLE;
              end
            end else begin
              r_line <= r_line + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_board_checker.sv
// tb_game_board_checker: directed vectors for 3x3 (timeout 5)
// and 4x4 (no timeout) boards.
module tb_game_board_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ng3 = 1'b0, v3 = 1'b0;
  logic [1:0] row3 = '0, col3 = '0, rdr3 = '0, rdc3 = '0;
  logic       rdy3, acc3, rej3, to3, cp3, go3, dr3;
  logic [1:0] win3, rd3;
  logic       ng4 = 1'b0, v4 = 1'b0;
  logic [1:0] row4 = '0, col4 = '0, rdr4 = '0, rdc4 = '0;
  logic       rdy4, acc4, rej4, to4, cp4, go4, dr4;
  logic [1:0] win4, rd4;
  int n_chk = 0;
  int n_err = 0;
  int wcnt = 0;

  int draw_mv [9][2] = '{'{0,0}, '{0,1}, '{0,2}, '{1,1}, '{1,0},
                         '{1,2}, '{2,1}, '{2,0}, '{2,2}};
  int win9_mv [9][2] = '{'{0,0}, '{0,1}, '{0,2}, '{1,0}, '{1,1},
                         '{1,2}, '{2,1}, '{2,0}, '{2,2}};
  int anti_mv [8][2] = '{'{0,0}, '{0,3}, '{0,1}, '{1,2}, '{1,0},
                         '{2,1}, '{1,1}, '{3,0}};

  always #5 clk = ~clk;

  game_board_checker #(.N(3), .TIMEOUT_CYCLES(5)) u_b3 (
    .i_clk(clk), .i_rst(rst), .i_new_game(ng3),
    .i_move_valid(v3), .o_move_ready(rdy3),
    .i_move_row(row3), .i_move_col(col3),
    .o_move_accept(acc3), .o_move_reject(rej3), .o_timeout(to3),
    .o_current_player(cp3), .o_game_over(go3), .o_winner(win3),
    .o_draw(dr3), .i_rd_row(rdr3), .i_rd_col(rdc3), .o_rd_data(rd3)
  );

  game_board_checker #(.N(4), .TIMEOUT_CYCLES(0)) u_b4 (
    .i_clk(clk), .i_rst(rst), .i_new_game(ng4),
    .i_move_valid(v4), .o_move_ready(rdy4),
    .i_move_row(row4), .i_move_col(col4),
    .o_move_accept(acc4), .o_move_reject(rej4), .o_timeout(to4),
    .o_current_player(cp4), .o_game_over(go4), .o_winner(win4),
    .o_draw(dr4), .i_rd_row(rdr4), .i_rd_col(rdc4), .o_rd_data(rd4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy(input int s);
    wcnt = 0;
    while (((s == 3) ? rdy3 : rdy4) !== 1'b1 && wcnt < 40) begin
      @(negedge clk);
      wcnt++;
    end
    chk("ready", (s == 3) ? rdy3 : rdy4, 1);
  endtask

  task automatic wait_go(input int s);
    wcnt = 0;
    while (((s == 3) ? go3 : go4) !== 1'b1 && wcnt < 40) begin
      @(negedge clk);
      wcnt++;
    end
  endtask

  task automatic wait_to();
    wcnt = 0;
    do begin
      @(negedge clk);
      wcnt++;
    end while (to3 !== 1'b1 && wcnt < 40);
  endtask

  task automatic mv(input int s, input int r, input int c);
    wait_rdy(s);
    if (s == 3) begin
      v3 = 1'b1; row3 = r[1:0]; col3 = c[1:0];
    end else begin
      v4 = 1'b1; row4 = r[1:0]; col4 = c[1:0];
    end
    @(negedge clk);
    v3 = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic rdchk(input string tag, input int s, input int r,
                       input int c, input logic [1:0] exp);
    if (s == 3) begin
      rdr3 = r[1:0]; rdc3 = c[1:0];
      #1 chk(tag, rd3, exp);
    end else begin
      rdr4 = r[1:0]; rdc4 = c[1:0];
      #1 chk(tag, rd4, exp);
    end
  endtask

  task automatic new_game3();
    ng3 = 1'b1;
    @(negedge clk);
    ng3 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", rdy3, 1);
    chk("rst_player", cp3, 0);
    chk("rst_over", go3, 0);
    chk("rst_winner", win3, 0);
    chk("rst_draw", dr3, 0);
    chk("rst_pulses", {acc3, rej3, to3}, 0);
    rdchk("rst_cell", 3, 1, 1, 2'b00);

    mv(3, 0, 0);
    chk("acc_first", acc3, 1);
    rdchk("wr_vis", 3, 0, 0, 2'b01);
    wait_rdy(3);
    chk("nowin_lat", wcnt, 8);
    chk("toggle", cp3, 1);
    mv(3, 1, 0);
    mv(3, 0, 1);
    mv(3, 1, 1);
    mv(3, 0, 2);
    chk("acc_last", acc3, 1);
    wait_go(3);
    chk("row_lat", wcnt, 1);
    chk("row_winner", win3, 2'b01);
    chk("row_ready", rdy3, 0);
    rdchk("rd_oor", 3, 3, 0, 2'b00);
    v3 = 1'b1; row3 = 2'd2; col3 = 2'd2;
    @(negedge clk);
    v3 = 1'b0;
    chk("over_ign", {acc3, rej3}, 0);
    rdchk("over_cell", 3, 2, 2, 2'b00);
    new_game3();
    chk("ng_ready", rdy3, 1);
    chk("ng_over", go3, 0);
    chk("ng_winner", win3, 0);
    chk("ng_player", cp3, 0);
    rdchk("ng_cell", 3, 0, 0, 2'b00);

    mv(3, 1, 1);
    wait_rdy(3);
    mv(3, 1, 1);
    chk("rej_occ", rej3, 1);
    chk("rej_occ_acc", acc3, 0);
    chk("rej_player", cp3, 1);
    rdchk("rej_cell", 3, 1, 1, 2'b01);
    mv(3, 3, 0);
    chk("rej_row", rej3, 1);
    chk("rej_row_player", cp3, 1);
    mv(3, 2, 2);
    chk("acc_after_rej", acc3, 1);
    rdchk("acc_after_cell", 3, 2, 2, 2'b10);
    wait_rdy(3);
    chk("after_rej_player", cp3, 0);

    new_game3();
    foreach (draw_mv[i]) mv(3, draw_mv[i][0], draw_mv[i][1]);
    wait_go(3);
    chk("draw_lat", wcnt, 8);
    chk("draw_flag", dr3, 1);
    chk("draw_winner", win3, 0);

    new_game3();
    foreach (win9_mv[i]) mv(3, win9_mv[i][0], win9_mv[i][1]);
    wait_go(3);
    chk("win9_lat", wcnt, 7);
    chk("win9_winner", win3, 2'b01);
    chk("win9_draw", dr3, 0);

    mv(4, anti_mv[0][0], anti_mv[0][1]);
    wait_rdy(4);
    chk("n4_nowin_lat", wcnt, 10);
    for (int i = 1; i < 8; i++) mv(4, anti_mv[i][0], anti_mv[i][1]);
    wait_go(4);
    chk("anti_lat", wcnt, 10);
    chk("anti_winner", win4, 2'b10);
    rdchk("anti_cell", 4, 3, 0, 2'b10);

    new_game3();
    ng3 = 1'b1; v3 = 1'b1; row3 = 2'd0; col3 = 2'd0;
    @(negedge clk);
    ng3 = 1'b0; v3 = 1'b0;
    chk("ng_ovr_pulse", {acc3, rej3}, 0);
    rdchk("ng_ovr_cell", 3, 0, 0, 2'b00);
    wait_to();
    chk("to_period1", wcnt, 5);
    chk("to_player1", cp3, 1);
    wait_to();
    chk("to_period2", wcnt, 5);
    chk("to_player2", cp3, 0);
    repeat (4) @(negedge clk);
    mv(3, 0, 0);
    chk("to_hs_acc", acc3, 1);
    chk("to_hs_to", to3, 0);
    wait_rdy(3);
    chk("to_hs_player", cp3, 1);
    mv(3, 0, 0);
    mv(3, 0, 0);
    chk("to_rej", rej3, 1);
    wait_to();
    chk("to_rej_keep", wcnt, 3);
    chk("to_rej_player", cp3, 0);

    mv(3, 1, 1);
    @(negedge clk);
    chk("ar_in_check", rdy3, 0);
    #1 rst = 1'b1;
    #1;
    chk("ar_ready", rdy3, 1);
    chk("ar_pulses", {acc3, rej3, to3}, 0);
    chk("ar_over4", {go4, win4}, 0);
    rdchk("ar_cell", 3, 1, 1, 2'b00);
    rdchk("ar_cell0", 3, 0, 0, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
